// File: rtl/game_ctl_if.sv
// Card-game controller bus: game control and click inputs, card writes and status outputs.
interface game_ctl_if #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned SCORE_W     = 6
);

    // Game control and player clicks
    logic                           start;
    logic [ADDR_W:0]                num_of_cards;
    logic                           card_pressed;
    logic [ADDR_W-1:0]              card_clicked_address;
    logic [COLOR_W-1:0]             card_clicked_color;

    // Card-state writes and game status
    logic                           wait_for_click_en;
    logic                           write_card_en;
    logic [ADDR_W-1:0]              write_card_address;
    logic [1:0]                     write_card_state;
    logic [1:0]                     active_player;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic [9:0]                     moves;
    logic                           stopwatch_en;
    logic                           stopwatch_disable;
    logic                           game_over;

    // Driver side: issues game control and clicks, observes the controller
    modport master (
        output start,
        output num_of_cards,
        output card_pressed,
        output card_clicked_address,
        output card_clicked_color,
        input  wait_for_click_en,
        input  write_card_en,
        input  write_card_address,
        input  write_card_state,
        input  active_player,
        input  scores,
        input  moves,
        input  stopwatch_en,
        input  stopwatch_disable,
        input  game_over
    );

    // Controller side
    modport slave (
        input  start,
        input  num_of_cards,
        input  card_pressed,
        input  card_clicked_address,
        input  card_clicked_color,
        output wait_for_click_en,
        output write_card_en,
        output write_card_address,
        output write_card_state,
        output active_player,
        output scores,
        output moves,
        output stopwatch_en,
        output stopwatch_disable,
        output game_over
    );

endinterface

// File: rtl/game_ctl.sv
// Memory-style card matching game controller: collects a group of clicks per turn,
// marks matched groups, hides mismatched ones after a hold time, tracks scores and turns.
module game_ctl #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned MATCH_SIZE  = 2,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned FLIP_HOLD   = 65000000,
    parameter int unsigned SCORE_W     = 6
) (
    input  logic      clk,
    input  logic      rst,
    game_ctl_if.slave bus
);

    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned IDX_W    = $clog2(MATCH_SIZE);
    localparam int unsigned HOLD_W   = (FLIP_HOLD > 1) ? $clog2(FLIP_HOLD) : 1;
    localparam int unsigned PROD_W   = CNT_W + 3;
    localparam int unsigned MOVES_W  = 10;
    localparam int unsigned SCORES_W = NUM_PLAYERS * SCORE_W;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(MATCH_SIZE - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(FLIP_HOLD - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam logic [MOVES_W-1:0] MOVES_MAX   = '1;
    localparam logic [1:0]         LAST_PLAYER = 2'(NUM_PLAYERS - 1);

    localparam logic [1:0] CARD_HIDDEN  = 2'd0;
    localparam logic [1:0] CARD_SHOWN   = 2'd1;
    localparam logic [1:0] CARD_MATCHED = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CLICK,
        S_HOLD,
        S_HIDE,
        S_MARK,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    // Turn bookkeeping
    logic [ADDR_W-1:0]   slot_addr_q  [MATCH_SIZE];
    logic [COLOR_W-1:0]  slot_color_q [MATCH_SIZE];
    logic [IDX_W-1:0]    sel_cnt_q,   sel_cnt_d;
    logic [IDX_W-1:0]    wr_idx_q,    wr_idx_d;
    logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic [CNT_W-1:0]    num_cards_q, num_cards_d;
    logic [CNT_W-1:0]    group_cnt_q, group_cnt_d;

    // Registered outputs
    logic [MOVES_W-1:0]  moves_q,    moves_d;
    logic [1:0]          player_q,   player_d;
    logic [SCORES_W-1:0] scores_q,   scores_d;
    logic                wait_q,     wait_d;
    logic                wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
    logic [1:0]          wr_state_q, wr_state_d;
    logic                sw_en_q,    sw_en_d;
    logic                sw_dis_q,   sw_dis_d;
    logic                over_q,     over_d;

    // Click qualification and turn decisions
    logic dup_c;
    logic same_color_c;
    logic in_range_c;
    logic accept_c;
    logic last_click_c;
    logic start_ok_c;
    logic hold_done_c;
    logic seq_last_c;
    logic all_cleared_c;

    // Detect a click on a card already selected this turn
    always_comb begin
        dup_c = 1'b0;
        for (int i = 0; i < int'(MATCH_SIZE); i++) begin
            if ((IDX_W'(i) < sel_cnt_q) && (slot_addr_q[i] == bus.card_clicked_address)) begin
                dup_c = 1'b1;
            end
        end
    end

    // Group matches when every earlier slot shares the color of the closing click
    always_comb begin
        same_color_c = 1'b1;
        for (int i = 0; i < int'(MATCH_SIZE) - 1; i++) begin
            if (slot_color_q[i] != bus.card_clicked_color) begin
                same_color_c = 1'b0;
            end
        end
    end

    assign in_range_c    = CNT_W'(bus.card_clicked_address) < num_cards_q;
    assign accept_c      = (state_q == S_WAIT_CLICK) && bus.card_pressed && in_range_c && !dup_c;
    assign last_click_c  = accept_c && (sel_cnt_q == LAST_IDX);
    assign start_ok_c    = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;
    assign hold_done_c   = (hold_cnt_q == HOLD_LAST);
    assign seq_last_c    = (wr_idx_q == LAST_IDX);
    assign all_cleared_c = ((PROD_W'(group_cnt_q) + PROD_W'(1)) * PROD_W'(MATCH_SIZE))
                           == PROD_W'(num_cards_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_c) state_d = S_WAIT_CLICK;
            end
            S_WAIT_CLICK: begin
                if (last_click_c) state_d = same_color_c ? S_MARK : S_HOLD;
            end
            S_HOLD: begin
                if (hold_done_c) state_d = S_HIDE;
            end
            S_HIDE: begin
                if (seq_last_c) state_d = S_WAIT_CLICK;
            end
            S_MARK: begin
                if (seq_last_c) state_d = all_cleared_c ? S_DONE : S_WAIT_CLICK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        sel_cnt_d   = sel_cnt_q;
        wr_idx_d    = wr_idx_q;
        hold_cnt_d  = hold_cnt_q;
        num_cards_d = num_cards_q;
        group_cnt_d = group_cnt_q;
        moves_d     = moves_q;
        player_d    = player_q;
        scores_d    = scores_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_state_d  = wr_state_q;
        sw_en_d     = 1'b0;
        sw_dis_d    = 1'b0;
        wait_d      = (state_d == S_WAIT_CLICK);
        over_d      = (state_d == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_c) begin
                    num_cards_d = bus.num_of_cards;
                    group_cnt_d = '0;
                    moves_d     = '0;
                    scores_d    = '0;
                    player_d    = '0;
                    sel_cnt_d   = '0;
                    sw_en_d     = 1'b1;
                end
            end
            S_WAIT_CLICK: begin
                if (accept_c) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = bus.card_clicked_address;
                    wr_state_d = CARD_SHOWN;
                    sel_cnt_d  = last_click_c ? '0 : sel_cnt_q + IDX_W'(1);
                    wr_idx_d   = '0;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            S_HIDE: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = slot_addr_q[wr_idx_q];
                wr_state_d = CARD_HIDDEN;
                wr_idx_d   = seq_last_c ? '0 : wr_idx_q + IDX_W'(1);
                if (seq_last_c) begin
                    if (moves_q != MOVES_MAX) moves_d = moves_q + MOVES_W'(1);
                    player_d = (player_q == LAST_PLAYER) ? 2'd0 : player_q + 2'd1;
                end
            end
            S_MARK: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = slot_addr_q[wr_idx_q];
                wr_state_d = CARD_MATCHED;
                wr_idx_d   = seq_last_c ? '0 : wr_idx_q + IDX_W'(1);
                if (seq_last_c) begin
                    if (moves_q != MOVES_MAX) moves_d = moves_q + MOVES_W'(1);
                    group_cnt_d = group_cnt_q + CNT_W'(1);
                    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                        if ((2'(p) == player_q) &&
                            (scores_q[p*SCORE_W +: SCORE_W] != SCORE_MAX)) begin
                            scores_d[p*SCORE_W +: SCORE_W] =
                                scores_q[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
                        end
                    end
                    if (all_cleared_c) sw_dis_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_cnt_q   <= '0;
            wr_idx_q    <= '0;
            hold_cnt_q  <= '0;
            num_cards_q <= '0;
            group_cnt_q <= '0;
            moves_q     <= '0;
            player_q    <= '0;
            scores_q    <= '0;
            wait_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_state_q  <= '0;
            sw_en_q     <= 1'b0;
            sw_dis_q    <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            sel_cnt_q   <= sel_cnt_d;
            wr_idx_q    <= wr_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            num_cards_q <= num_cards_d;
            group_cnt_q <= group_cnt_d;
            moves_q     <= moves_d;
            player_q    <= player_d;
            scores_q    <= scores_d;
            wait_q      <= wait_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_state_q  <= wr_state_d;
            sw_en_q     <= sw_en_d;
            sw_dis_q    <= sw_dis_d;
            over_q      <= over_d;
        end
    end

    // Selection slots: capture address and color of each accepted click in order
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MATCH_SIZE); i++) begin
                slot_addr_q[i]  <= '0;
                slot_color_q[i] <= '0;
            end
        end else if (accept_c) begin
            slot_addr_q[sel_cnt_q]  <= bus.card_clicked_address;
            slot_color_q[sel_cnt_q] <= bus.card_clicked_color;
        end
    end

    assign bus.wait_for_click_en  = wait_q;
    assign bus.write_card_en      = wr_en_q;
    assign bus.write_card_address = wr_addr_q;
    assign bus.write_card_state   = wr_state_q;
    assign bus.active_player      = player_q;
    assign bus.scores             = scores_q;
    assign bus.moves              = moves_q;
    assign bus.stopwatch_en       = sw_en_q;
    assign bus.stopwatch_disable  = sw_dis_q;
    assign bus.game_over          = over_q;

endmodule
